cpu_controller: RTL and testbench
=================================

# cpu_controller

Multi-cycle control FSM for the ARM-subset CPU, directly downstream of the instruction-fetch stage. It drives the fetch stage's `write_ir` and `write_pc` strobes and owns the architectural `NZCV` register that fetch uses for condition evaluation. It consumes the latched `IR` and fetch's `W_IR_valid`, decodes data-processing instructions, and sequences register-file reads, the ALU and write-back.

## Interface
- No parameters.
- `clk` input 1: single system clock. State advances on the rising edge. `ir_taken` is captured on the falling edge, because the fetch stage latches IR on the falling edge.
- `rst` input 1: asynchronous, active-high reset.
- `IR` input 32: instruction latched by the fetch stage.
- `W_IR_valid` input 1: fetch stage's condition-passed AND `write_ir`.
- `alu_nzcv` input 4: flags from the datapath ALU, ordered {N,Z,C,V}.
- `write_ir` output 1: IR load strobe to the fetch stage.
- `write_pc` output 1: PC+4 strobe to the fetch stage.
- `NZCV` output 4: architectural flags, bit3=N, bit2=Z, bit1=C, bit0=V.
- `rf_ra`, `rf_rb`, `rf_wa` output 4 each: register-file read addresses A and B, and the write address.
- `latch_ab` output 1: capture register-file operands A and B.
- `latch_f` output 1: capture the ALU result.
- `rf_we` output 1: register-file write enable.
- `alu_op` output 4: equal to `IR[24:21]`.
- `op_b_imm` output 1: selects the immediate as operand B (`IR[25]`).
- `imm8` output 8: `IR[7:0]`.
- `imm_rot` output 4: `IR[11:8]`.
- `undef` output 1: one-cycle pulse on a non-data-processing instruction.
- `cycle_cnt`, `instr_cnt` output 32 each: performance counters (see Configuration).

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, WB.
- **IDLE:** all strobes low. Moves to FETCH on the next cycle.
- **FETCH:** `write_ir`=1 and `write_pc`=1 for exactly one cycle.
  - On the falling edge within FETCH, `ir_taken` is sampled from `W_IR_valid`.
  - `ir_taken`=0 (condition failed): next state is FETCH. The PC has advanced, so the instruction is skipped.
  - `ir_taken`=1: next state is DECODE.
- **DECODE:**
  - If `IR[27:26]` != 00: `undef` pulses for 1 cycle and the next state is FETCH.
  - Otherwise: `latch_ab`=1, `rf_ra`=`IR[19:16]`, `rf_rb`=`IR[3:0]`, and the next state is EXEC.
- **EXEC:** `latch_f`=1, with `alu_op` and `op_b_imm` valid.
  - Flag update happens when `IR[20]`=1, or when the opcode is 10xx (TST/TEQ/CMP/CMN).
  - For arithmetic opcodes (0010–0111, 1010, 1011), the update writes all of `NZCV` from `alu_nzcv`.
  - For logical opcodes, the update writes N and Z only; C and V hold.
  - Opcode 10xx goes to FETCH (no write-back). All other opcodes go to WB.
- **WB:** `rf_we`=1, `rf_wa`=`IR[15:12]`. Next state is FETCH.
- **Decode outputs:** `alu_op`, `imm8`, `imm_rot`, `op_b_imm` and the read addresses decode combinationally from `IR` in every state. The strobes are Moore outputs of the state register.
- **Flag writes:** `NZCV` is written only in EXEC.

## Timing
- **Reset:** while `rst` is high, and immediately on assertion, state=IDLE and `ir_taken`=0.
  - All strobes, `undef` and `NZCV` are 0.
  - Counters are cleared.
  - Reset mid-instruction aborts it with no register write. A pending `rf_we` drops asynchronously.
- **First FETCH:** occurs in the 2nd rising edge after reset release (IDLE occupies one cycle).
- **Instruction latency:** 4 cycles with write-back, 3 cycles flag-only, 2 cycles undefined, 1 cycle condition-failed.
- **Strobe stability:** strobes change only after a rising edge, so they are stable at the fetch stage's falling-edge sampling point.
- **Flag visibility:** `NZCV` updated in EXEC is visible to the very next FETCH's condition check.
- **Counter wrap:** both counters wrap modulo 2^32 with no saturation.

## Configuration
- `CPU_CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle when not in reset.
  - `instr_cnt` increments once per retired instruction. Retirement is leaving WB, or leaving EXEC for opcode 10xx.
  - Skipped and undefined instructions are not counted.
- Undefined: both counter ports are tied to 32'h0 and no counter registers are synthesized.

## Test plan
- **Reset then ADD:** reset, then `IR`=32'hE0812003 (ADD r2,r1,r3) with `W_IR_valid`=1.
  - Expect strobes FETCH→DECODE→EXEC→WB.
  - Expect `rf_ra`=1, `rf_rb`=3, `rf_we`=1 with `rf_wa`=2 on cycle 4.
  - Expect `NZCV` unchanged (0).
- **SUBS flags:** SUBS (`IR[20]`=1, opcode 0010) with `alu_nzcv`=4'b0110 in EXEC.
  - Expect `NZCV`=4'b0110 from the next cycle.
- **Logical-op flags:** ANDS with `NZCV`=4'b0011 and `alu_nzcv`=4'b1000.
  - Expect `NZCV`=4'b1011 (C and V preserved).
- **Flag-only op:** CMP (opcode 1010).
  - Expect no WB state, `rf_we` never asserted, and return to FETCH after EXEC.
- **Condition fail:** `W_IR_valid`=0 during FETCH.
  - Expect FETCH repeated on the next cycle with `write_pc` high again and `instr_cnt` unchanged.
- **Undefined and reset abort:** `IR[27:26]`=01 in DECODE.
  - Expect a 1-cycle `undef` pulse and FETCH next.
  - Assert `rst` during WB: `rf_we` drops immediately and the state goes to IDLE.

Source files
------------

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the ARM-subset CPU: sequences fetch, decode, execute and write-back.
// Optional performance counters are built when CPU_CTRL_PERF_CNT_EN is defined.
module cpu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic        W_IR_valid,
  input  logic [3:0]  alu_nzcv,
  output logic        write_ir,
  output logic        write_pc,
  output logic [3:0]  NZCV,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  output logic [3:0]  rf_wa,
  output logic        latch_ab,
  output logic        latch_f,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic        op_b_imm,
  output logic [7:0]  imm8,
  output logic [3:0]  imm_rot,
  output logic        undef,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state_reg, state_next;
  logic        ir_taken_reg;
  logic [3:0]  nzcv_reg, nzcv_next;
  logic        dp_instr;
  logic        cmp_class;
  logic        flag_upd;
  logic        arith_op;
  logic        unused_ir;

  assign dp_instr  = (IR[27:26] == 2'b00);
  assign cmp_class = (IR[24:23] == 2'b10);
  assign flag_upd  = IR[20] | cmp_class;
  assign unused_ir = ^IR[31:28];

  always_comb begin
    arith_op = 1'b0;
    case (IR[24:21])
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: arith_op = 1'b1;
      default:                            arith_op = 1'b0;
    endcase
  end

  // Decode fields are pure wiring from IR, valid in every state.
  assign alu_op   = IR[24:21];
  assign op_b_imm = IR[25];
  assign imm8     = IR[7:0];
  assign imm_rot  = IR[11:8];
  assign rf_ra    = IR[19:16];
  assign rf_rb    = IR[3:0];
  assign rf_wa    = IR[15:12];
  assign NZCV     = nzcv_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      nzcv_reg  <= 4'b0000;
    end else begin
      state_reg <= state_next;
      nzcv_reg  <= nzcv_next;
    end
  end

  // Fetch latches IR on the falling edge, so the condition result is taken there too.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ir_taken_reg <= 1'b0;
    end else if (state_reg == S_FETCH) begin
      ir_taken_reg <= W_IR_valid;
    end
  end

  always_comb begin
    state_next = state_reg;
    nzcv_next  = nzcv_reg;
    write_ir   = 1'b0;
    write_pc   = 1'b0;
    latch_ab   = 1'b0;
    latch_f    = 1'b0;
    rf_we      = 1'b0;
    undef      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        write_ir   = 1'b1;
        write_pc   = 1'b1;
        state_next = ir_taken_reg ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (dp_instr) begin
          latch_ab   = 1'b1;
          state_next = S_EXEC;
        end else begin
          undef      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        latch_f = 1'b1;
        // Logical ops only own N and Z; C and V carry over.
        if (flag_upd) begin
          nzcv_next = arith_op ? alu_nzcv : {alu_nzcv[3:2], nzcv_reg[1:0]};
        end
        state_next = cmp_class ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we      = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instr_cnt_reg;
  logic        retire;

  assign retire = (state_reg == S_WB) || ((state_reg == S_EXEC) && cmp_class);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg <= 32'h0;
      instr_cnt_reg <= 32'h0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (retire) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`else
  assign cycle_cnt = 32'h0;
  assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed table, randomized instructions against an
// instruction-level reference model, and a reset-abort sequence.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = 32'h0;
  logic        w_ir_valid = 1'b0;
  logic [3:0]  alu_nzcv = 4'h0;
  logic        write_ir, write_pc, latch_ab, latch_f, rf_we, op_b_imm, undef;
  logic [3:0]  nzcv, rf_ra, rf_rb, rf_wa, alu_op, imm_rot;
  logic [7:0]  imm8;
  logic [31:0] cycle_cnt, instr_cnt;

  cpu_controller dut (
    .clk(clk), .rst(rst), .IR(ir), .W_IR_valid(w_ir_valid), .alu_nzcv(alu_nzcv),
    .write_ir(write_ir), .write_pc(write_pc), .NZCV(nzcv),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
    .latch_ab(latch_ab), .latch_f(latch_f), .rf_we(rf_we),
    .alu_op(alu_op), .op_b_imm(op_b_imm), .imm8(imm8), .imm_rot(imm_rot),
    .undef(undef), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Reference model: architectural flags, retired-instruction count, cycles since reset release.
  int cyc = 0;
  int icnt = 0;
  logic [3:0] flags = 4'h0;

  typedef struct {
    logic [31:0] ir;
    logic        v;
    logic [3:0]  af;
    logic [3:0]  exp_nzcv;
    int          exp_we;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cycles();
`ifdef CPU_CTRL_PERF_CNT_EN
    return 32'(cyc);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_instrs();
`ifdef CPU_CTRL_PERF_CNT_EN
    return 32'(icnt);
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_cycle(input string phase, input logic [5:0] exp_strb, input logic [31:0] cur_ir);
    logic [31:0] exp_dec;
    exp_dec = (((cur_ir >> 16) & 32'hF) << 25) | ((cur_ir & 32'hF) << 21) |
              (((cur_ir >> 12) & 32'hF) << 17) | (((cur_ir >> 21) & 32'hF) << 13) |
              (((cur_ir >> 25) & 32'h1) << 12) | ((cur_ir & 32'hFF) << 4) |
              ((cur_ir >> 8) & 32'hF);
    check({phase, " strobes"}, 32'({write_ir, write_pc, latch_ab, latch_f, rf_we, undef}), 32'(exp_strb));
    check({phase, " decode"}, 32'({rf_ra, rf_rb, rf_wa, alu_op, op_b_imm, imm8, imm_rot}), exp_dec);
    check({phase, " nzcv"}, 32'(nzcv), 32'(flags));
    check({phase, " cycle_cnt"}, cycle_cnt, exp_cycles());
    check({phase, " instr_cnt"}, instr_cnt, exp_instrs());
  endtask

  // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the cycle after the instruction.
  task automatic exec_instr(input logic [31:0] i_ir, input logic v, input logic [3:0] af, output int we_seen);
    int opc;
    int n;
    bit dp, cmpop, arith, upd;
    opc   = int'((i_ir >> 21) & 32'hF);
    dp    = ((i_ir >> 26) & 32'h3) == 0;
    cmpop = (opc >= 8) && (opc <= 11);
    upd   = (((i_ir >> 20) & 32'h1) != 0) || cmpop;
    arith = ((opc >= 2) && (opc <= 7)) || (opc == 10) || (opc == 11);
    n     = !v ? 1 : (!dp ? 2 : (cmpop ? 3 : 4));
    ir = i_ir;
    w_ir_valid = v;
    alu_nzcv = af;
    we_seen = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      #2;
      case (k)
        0: check_cycle("FETCH", 6'b110000, i_ir);
        1: check_cycle("DECODE", dp ? 6'b001000 : 6'b000001, i_ir);
        2: check_cycle("EXEC", 6'b000100, i_ir);
        default: check_cycle("WB", 6'b000010, i_ir);
      endcase
      if (rf_we) we_seen++;
      if (k == 2 && upd) flags = arith ? af : {af[3:2], flags[1:0]};
      if ((k == 2 && cmpop) || k == 3) icnt++;
    end
    $display("instr ir=%h valid=%0d cycles=%0d nzcv_model=%b instr_model=%0d", i_ir, v, n, flags, icnt);
    tick();
  endtask

  initial begin
    int we;
    tbl[0] = '{32'hE0812003, 1'b1, 4'b1111, 4'b0000, 1}; // ADD, flags untouched
    tbl[1] = '{32'hE0512003, 1'b1, 4'b0110, 4'b0110, 1}; // SUBS
    tbl[2] = '{32'hE0912003, 1'b1, 4'b0011, 4'b0011, 1}; // ADDS
    tbl[3] = '{32'hE0112003, 1'b1, 4'b1000, 4'b1011, 1}; // ANDS keeps C,V
    tbl[4] = '{32'hE1510003, 1'b1, 4'b0100, 4'b0100, 0}; // CMP, no WB
    tbl[5] = '{32'h00812003, 1'b0, 4'b1111, 4'b0100, 0}; // condition failed
    tbl[6] = '{32'hE5912000, 1'b1, 4'b1111, 4'b0100, 0}; // undefined (LDR)
    tbl[7] = '{32'hE3110FFF, 1'b1, 4'b1111, 4'b1100, 0}; // TST imm, logical
    tbl[8] = '{32'hE3A020AB, 1'b1, 4'b1010, 4'b1100, 1}; // MOV imm, no S
    tbl[9] = '{32'hE1912003, 1'b1, 4'b0001, 4'b0000, 1}; // ORRS

    // Reset held with a valid instruction presented: nothing may move.
    ir = 32'hE0812003;
    w_ir_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset strobes", 32'({write_ir, write_pc, latch_ab, latch_f, rf_we, undef}), 32'h0);
    check("reset nzcv", 32'(nzcv), 32'h0);
    check("reset cycle_cnt", cycle_cnt, 32'h0);
    check("reset instr_cnt", instr_cnt, 32'h0);
    rst = 1'b0;
    cyc = 0;
    #2;
    check_cycle("IDLE", 6'b000000, ir);
    tick();

    for (int i = 0; i < 10; i++) begin
      exec_instr(tbl[i].ir, tbl[i].v, tbl[i].af, we);
      check("table nzcv", 32'(nzcv), 32'(tbl[i].exp_nzcv));
      check("table rf_we cycles", 32'(we), 32'(tbl[i].exp_we));
    end

    for (int i = 0; i < 200; i++) begin
      logic [31:0] r_ir;
      logic r_v;
      r_ir = $urandom;
      if ($urandom_range(0, 99) < 80) r_ir = r_ir & ~(32'h3 << 26);
      r_v = ($urandom_range(0, 99) < 85);
      exec_instr(r_ir, r_v, 4'($urandom_range(0, 15)), we);
    end

    // Reset arriving during WB must kill rf_we at once and clear flags and counters.
    exec_instr(32'hE0912003, 1'b1, 4'b1001, we);
    ir = 32'hE0812003;
    w_ir_valid = 1'b1;
    #2;
    check_cycle("FETCH", 6'b110000, ir);
    tick(); #2; check_cycle("DECODE", 6'b001000, ir);
    tick(); #2; check_cycle("EXEC", 6'b000100, ir);
    tick(); #2; check_cycle("WB", 6'b000010, ir);
    rst = 1'b1;
    #1;
    check("abort rf_we", 32'(rf_we), 32'h0);
    check("abort strobes", 32'({write_ir, write_pc, latch_ab, latch_f, rf_we, undef}), 32'h0);
    check("abort nzcv", 32'(nzcv), 32'h0);
    check("abort cycle_cnt", cycle_cnt, 32'h0);
    check("abort instr_cnt", instr_cnt, 32'h0);
    @(posedge clk);
    #1;
    check("abort held strobes", 32'({write_ir, write_pc, latch_ab, latch_f, rf_we, undef}), 32'h0);
    rst = 1'b0;
    cyc = 0;
    icnt = 0;
    flags = 4'h0;
    #2;
    check_cycle("IDLE", 6'b000000, ir);
    tick();
    exec_instr(32'hE0512003, 1'b1, 4'b0110, we);
    check("post-abort nzcv", 32'(nzcv), 32'h6);
    check("post-abort rf_we cycles", 32'(we), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
